// File: rtl/adder_pkg.sv
// Shared helpers for the pipelined ripple-carry adder: chunk sizing, split legality,
// and the per-stage carry/valid record.
package adder_pkg;

  localparam int DEF_WIDTH  = 16;
  localparam int DEF_STAGES = 4;

  typedef struct packed {
    logic vld;
    logic carry;
  } stage_ctl_t;

  function automatic int chunk_w(input int width, input int stages);
    return width / stages;
  endfunction

  function automatic bit split_ok(input int width, input int stages);
    return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
  endfunction

endpackage

// File: rtl/rca_chunk.sv
// CW-bit combinational ripple adder built from full adders.
module rca_chunk #(
  parameter int CW = 4
) (
  input  logic [CW-1:0] a,
  input  logic [CW-1:0] b,
  input  logic          ci,
  output logic [CW-1:0] s,
  output logic          co
);

  logic [CW:0] w_c;

  assign w_c[0] = ci;

  for (genvar i = 0; i < CW; i++) begin : g_fa
    assign s[i]     = a[i] ^ b[i] ^ w_c[i];
    assign w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
  end

  assign co = w_c[CW];

endmodule

// File: rtl/pipelined_rca.sv
// Pipelined ripple-carry adder/subtractor: STAGES chunks of WIDTH/STAGES bits, one op/cycle.
// Define PIPELINED_RCA_OVF_EN to add the registered signed-overflow output ovf.
module pipelined_rca
  import adder_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int STAGES = DEF_STAGES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef PIPELINED_RCA_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = chunk_w(WIDTH, STAGES);

  if (!split_ok(WIDTH, STAGES)) begin : g_bad_split
    $error("pipelined_rca: WIDTH must be a multiple of STAGES and STAGES in 1..WIDTH");
  end

  logic             w_en;
  logic [WIDTH-1:0] w_beff;
  logic             w_c0;

  assign w_en     = !out_valid || out_ready;
  assign in_ready = w_en;
  assign w_beff   = b ^ {WIDTH{sub}};
  assign w_c0     = sub | cin;

  // Stage k owns sum chunks 0..k and still carries the untouched upper operand chunks.
  for (genvar k = 0; k < STAGES; k++) begin : g_st
    localparam int SW = (k + 1) * CW;

    logic [CW-1:0] w_ca, w_cb, w_s;
    logic          w_ci, w_co, w_vin;
    logic [SW-1:0] w_s_nxt;
    stage_ctl_t    r_ctl;
    logic [SW-1:0] r_s;

    if (k == 0) begin : g_src
      assign w_ca    = a[CW-1:0];
      assign w_cb    = w_beff[CW-1:0];
      assign w_ci    = w_c0;
      assign w_vin   = in_valid;
      assign w_s_nxt = w_s;
    end else begin : g_src
      assign w_ca    = g_st[k-1].g_op.r_a[CW-1:0];
      assign w_cb    = g_st[k-1].g_op.r_b[CW-1:0];
      assign w_ci    = g_st[k-1].r_ctl.carry;
      assign w_vin   = g_st[k-1].r_ctl.vld;
      assign w_s_nxt = {w_s, g_st[k-1].r_s};
    end

    rca_chunk #(.CW(CW)) u_chunk (
      .a  (w_ca),
      .b  (w_cb),
      .ci (w_ci),
      .s  (w_s),
      .co (w_co)
    );

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_ctl <= '0;
        r_s   <= '0;
      end else if (w_en) begin
        r_ctl <= '{vld: w_vin, carry: w_co};
        r_s   <= w_s_nxt;
      end
    end

    if (k < STAGES - 1) begin : g_op
      localparam int OW = WIDTH - SW;

      logic [OW-1:0] w_a_nxt, w_b_nxt;
      logic [OW-1:0] r_a, r_b;

      if (k == 0) begin : g_osrc
        assign w_a_nxt = a[WIDTH-1:CW];
        assign w_b_nxt = w_beff[WIDTH-1:CW];
      end else begin : g_osrc
        assign w_a_nxt = g_st[k-1].g_op.r_a[OW+CW-1:CW];
        assign w_b_nxt = g_st[k-1].g_op.r_b[OW+CW-1:CW];
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_a <= '0;
          r_b <= '0;
        end else if (w_en) begin
          r_a <= w_a_nxt;
          r_b <= w_b_nxt;
        end
      end
    end
  end

  assign out_valid = g_st[STAGES-1].r_ctl.vld;
  assign cout      = g_st[STAGES-1].r_ctl.carry;
  assign sum       = g_st[STAGES-1].r_s;

`ifdef PIPELINED_RCA_OVF_EN
  // Top chunk still sees the true operand MSBs, so overflow is decided alongside it.
  logic r_ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if (w_en) begin
      r_ovf <= (g_st[STAGES-1].w_ca[CW-1] == g_st[STAGES-1].w_cb[CW-1]) &&
               (g_st[STAGES-1].w_s[CW-1]  != g_st[STAGES-1].w_ca[CW-1]);
    end
  end

  assign ovf = r_ovf;
`endif

endmodule

// File: tb/tb_pipelined_rca.sv
// Scoreboard bench for pipelined_rca (WIDTH=16, STAGES=4): driver pushes expectations,
// a negedge monitor pops and compares every output transfer.
module tb_pipelined_rca;

  localparam int W = 16;
  localparam int S = 4;

  logic         clk = 1'b0;
  logic         rst_n, in_valid, in_ready, cin, sub, out_valid, out_ready, cout;
  logic [W-1:0] a, b, sum;
`ifdef PIPELINED_RCA_OVF_EN
  logic         ovf;
`endif

  typedef struct {
    logic [W:0] res;
    logic       ovf;
  } exp_t;

  typedef struct {
    logic [W-1:0] a, b;
    logic         cin, sub;
    logic [W:0]   res;
    logic         ovf;
  } vec_t;

  exp_t sb[$];
  int   checks = 0, errors = 0, n_out = 0, n_stall = 0;

  always #5 clk = ~clk;

  pipelined_rca #(.WIDTH(W), .STAGES(S)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
`ifdef PIPELINED_RCA_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic [W:0] res, input logic ov);
    exp_t e;
    e.res = res;
    e.ovf = ov;
    return e;
  endfunction

  function automatic exp_t gold(input logic [W-1:0] x, input logic [W-1:0] y,
                                input logic ci, input logic s);
    exp_t         e;
    logic [W-1:0] yb;
    yb    = y ^ {W{s}};
    e.res = {1'b0, x} + {1'b0, yb} + {{W{1'b0}}, (s | ci)};
    e.ovf = (x[W-1] == yb[W-1]) && (e.res[W-1] != x[W-1]);
    return e;
  endfunction

  // Called at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic send(input logic [W-1:0] x, input logic [W-1:0] y,
                      input logic ci, input logic s, input exp_t e);
    a = x; b = y; cin = ci; sub = s; in_valid = 1'b1;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back(e);
        @(posedge clk); #1;
        return;
      end
      n_stall++;
      @(posedge clk); #1;
    end
    checks++; errors++;
    $display("FAIL send_timeout: got in_ready 0 expected 1 within 200 cycles");
  endtask

  task automatic drain();
    for (int t = 0; t < 200 && sb.size() > 0; t++) begin
      @(posedge clk); #1;
    end
    chk("drain_empty", sb.size(), 0);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      exp_t e;
      n_out++;
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_output: got sum %0h cout %0b expected no output", sum, cout);
      end else begin
        e = sb.pop_front();
        chk("result", {15'd0, cout, sum}, {15'd0, e.res});
`ifdef PIPELINED_RCA_OVF_EN
        chk("ovf", ovf, e.ovf);
`endif
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t dv[9];
    int   n0;
    dv[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 17'h10000, 1'b0};
    dv[1] = '{16'hFFFF, 16'h0000, 1'b1, 1'b0, 17'h10000, 1'b0};
    dv[2] = '{16'h0005, 16'h0007, 1'b1, 1'b1, 17'h0FFFE, 1'b0};
    dv[3] = '{16'h0007, 16'h0005, 1'b0, 1'b1, 17'h10002, 1'b0};
    dv[4] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 17'h08000, 1'b1};
    dv[5] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 17'h17FFF, 1'b1};
    dv[6] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 17'h05555, 1'b0};
    dv[7] = '{16'h0000, 16'h0000, 1'b1, 1'b1, 17'h10000, 1'b0};
    dv[8] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 17'h1FFFF, 1'b0};

    rst_n = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
    chk("rst_in_ready", in_ready, 1);
`ifdef PIPELINED_RCA_OVF_EN
    chk("rst_ovf", ovf, 0);
`endif
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 10; i++) begin
      chk("idle_out_valid", out_valid, 0);
      @(posedge clk); #1;
    end

    // Full-chain carry, with latency: valid only after the (S-1)th edge past acceptance.
    send(dv[0].a, dv[0].b, dv[0].cin, dv[0].sub, mk(dv[0].res, dv[0].ovf));
    in_valid = 1'b0;
    for (int s = 0; s < S; s++) begin
      chk("latency_out_valid", out_valid, (s == S - 1));
      if (s < S - 1) begin @(posedge clk); #1; end
    end
    drain();

    for (int i = 1; i < 9; i++)
      send(dv[i].a, dv[i].b, dv[i].cin, dv[i].sub, mk(dv[i].res, dv[i].ovf));
    in_valid = 1'b0;
    drain();

    // Streaming: nibble pairs placed in varying chunks, then random sets.
    n_stall = 0;
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        int           n;
        logic [W-1:0] x, y;
        n = i * 16 + j;
        x = 16'(i) << (4 * (n % 4));
        y = 16'(j) << (4 * ((n / 4) % 4));
        send(x, y, n[1], n[0], gold(x, y, n[1], n[0]));
      end
    end
    for (int i = 0; i < 256; i++) begin
      logic [W-1:0] x, y;
      logic         c, s;
      x = 16'($urandom); y = 16'($urandom);
      c = 1'($urandom); s = 1'($urandom);
      send(x, y, c, s, gold(x, y, c, s));
    end
    in_valid = 1'b0;
    chk("stream_no_stall", n_stall, 0);
    drain();

    // Backpressure: fill all stages, hold 3 cycles, then release.
    out_ready = 1'b0;
    n0 = n_out;
    for (int i = 2; i < 6; i++)
      send(dv[i].a, dv[i].b, dv[i].cin, dv[i].sub, mk(dv[i].res, dv[i].ovf));
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("bp_in_ready", in_ready, 0);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_frozen", {15'd0, cout, sum}, {15'd0, sb[0].res});
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i <= S; i++) begin
      chk("bp_drain_valid", out_valid, (i < S));
      @(posedge clk); #1;
    end
    chk("bp_count", n_out - n0, 4);
    chk("bp_sb_empty", sb.size(), 0);

    // Mid-flight reset with three operations in the pipe.
    out_ready = 1'b0;
    for (int i = 6; i < 9; i++)
      send(dv[i].a, dv[i].b, dv[i].cin, dv[i].sub, mk(dv[i].res, dv[i].ovf));
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("mid_out_valid_before", out_valid, 1);
    #3 rst_n = 1'b0;
    #1;
    chk("mid_out_valid", out_valid, 0);
    chk("mid_sum", sum, 0);
    chk("mid_cout", cout, 0);
    chk("mid_in_ready", in_ready, 1);
    sb.delete();
    n0 = n_out;
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    idle(12);
    chk("mid_no_results", n_out - n0, 0);
    chk("mid_idle_valid", out_valid, 0);

    send(dv[3].a, dv[3].b, dv[3].cin, dv[3].sub, mk(dv[3].res, dv[3].ovf));
    in_valid = 1'b0;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipelined_rca.md
# pipelined_rca

Parametrised, pipelined ripple-carry adder/subtractor, the successor to the 4-bit combinational `rca`. The WIDTH-bit carry chain is split into STAGES equal chunks with a register between chunks, so the block sustains one operation per cycle at a clock rate set by one chunk's carry chain. A valid/ready handshake on each side, plus global stall, lets it sit directly in streaming datapaths.

## Interface
- `WIDTH`, 16: operand and sum width; must be a multiple of STAGES.
- `STAGES`, 4: pipeline depth, range 1..WIDTH. Chunk width CW = WIDTH/STAGES.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset; asynchronous assert, active-low.
- `in_valid`  in  1  operand set present.
- `in_ready`  out  1  block accepts the operand set this cycle.
- `a`, `b`  in  WIDTH  operands.
- `cin`  in  1  carry-in; ignored when `sub`=1.
- `sub`  in  1  0: a+b+cin; 1: a−b.
- `out_valid`  out  1  result present.
- `out_ready`  in  1  downstream accepts the result.
- `sum`  out  WIDTH  result, modulo 2^WIDTH.
- `cout`  out  1  carry-out. When `sub`=1, this is the inverted borrow: 1 iff a ≥ b unsigned.
- `ovf`  out  1  signed overflow; present only under PIPELINED_RCA_OVF_EN.

## Operation
- Effective operand: b' = b XOR {WIDTH{sub}}. Effective carry-in: c0 = sub ? 1 : cin.
- Transfer on input: `in_valid` && `in_ready` at a rising edge. Transfer on output: `out_valid` && `out_ready` at a rising edge.
- Stage k (0..STAGES−1) adds chunk k of a and b' using the carry registered by stage k−1. Stage 0 uses c0.
- Upper operand chunks are skewed forward through registers. Completed lower sum chunks are delayed so that all chunks of one result align at the final stage.
- Global enable: en = !out_valid || out_ready. All pipeline registers, including the valid bits, advance only when en=1. `in_ready` = en.
- Bubbles are not compressed. A valid bit of 0 propagates as a bubble.
- Results leave in acceptance order. No operation is dropped or duplicated.
- Arithmetic: {cout,sum} = a + b' + c0, exact at WIDTH+1 bits.
- Reset, at any time including mid-operation: every valid bit goes to 0, and `sum`, `cout` and `ovf` go to 0. In-flight operations are discarded. After reset, `in_ready`=1.

## Timing
- Latency: an operation accepted at edge t0 appears on `out_valid`/`sum` after edge t0+STAGES−1. That is STAGES edges, counting the accepting edge.
- STAGES=1: a single registered adder with one cycle of latency.
- Throughput: one result per cycle while `out_ready`=1.
- Stall: while `out_valid`=1 and `out_ready`=0, `sum`/`cout`/`ovf` hold stable and `in_ready`=0 in the same cycle (combinational path from `out_ready`).
- Simultaneous output transfer and input transfer in the same cycle is legal and required at full throughput.
- Outputs come directly from registers. `in_ready` is the only combinational output.

## Configuration
- `PIPELINED_RCA_OVF_EN` defined: adds the `ovf` port. ovf = (a[MSB] == b'[MSB]) && (sum[MSB] != a[MSB]). It is carried alongside the final chunk and registered with `sum`, and its reset value is 0.
- Not defined: no `ovf` port and no related logic. All other behaviour is identical.

## Structure
- Package `adder_pkg`: `localparam` helpers for chunk width and a WIDTH%STAGES legality check (elaboration-time error), plus a `typedef` for the per-stage carry/valid record.
- Sub-module `rca_chunk`: a CW-bit combinational ripple adder built from full adders (a, b, ci → s, co). It is instantiated once per stage via generate.
- Top level holds only the registers, skew/deskew shift chains and handshake logic.

## Test plan
Scenarios use WIDTH=16 and STAGES=4.
- Reset: hold `rst_n`=0 → `out_valid`=0, `sum`=0000, `cout`=0, `in_ready`=1. Release, then idle 10 cycles → `out_valid` stays 0.
- Full-chain carry: a=FFFF, b=0001, cin=0, sub=0 accepted at edge 1 → `out_valid`=1 after edge 4, `sum`=0000, `cout`=1. A second case, a=FFFF, b=0000, cin=1, gives the same result.
- Subtract: a=0005, b=0007, sub=1, cin=1 → `sum`=FFFE, `cout`=0. With a=0007, b=0005 → `sum`=0002, `cout`=1. Under OVF_EN, a=7FFF, b=0001, add → `sum`=8000, `ovf`=1. And a=8000, b=0001, sub → `sum`=7FFF, `ovf`=1.
- Streaming: all pairs a,b ∈ {0..15}×{0..15} shifted into varied chunks, plus 256 random sets with `out_ready`=1 → one result per cycle, in order, each matching the golden a+b'+c0.
- Backpressure: pipeline full, `out_ready`=0 for 3 cycles → `in_ready`=0, outputs frozen. Resume → remaining results emerge consecutively with no loss or duplication.
- Mid-flight reset: 3 operations in flight, pulse `rst_n` low asynchronously between edges → `out_valid` falls immediately, and none of the 3 results ever appears.
